// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master among four requesters.
// Define I2C_ARB_TIMEOUT_EN to add the WAIT timeout counter and abort path.
module i2c_req_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535,
    parameter logic [7:0]  HOLDOFF_CYCLES = 8'd8
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [27:0] req_addr,
    input  logic [3:0]  req_rw,
    input  logic [31:0] req_wdata,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [7:0]  rdata,
    output logic        nack,
    output logic        err_timeout,
    output logic        busy,
    output logic        m_start,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [7:0]  m_wdata,
    output logic        m_abort,
    input  logic        m_done,
    input  logic        m_ack_ok,
    input  logic [7:0]  m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic [6:0]  m_addr_q, m_addr_d;
    logic        m_rw_q, m_rw_d;
    logic [7:0]  m_wdata_q, m_wdata_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        hold_last;

    logic [1:0]  winner;
    logic        winner_vld;
    logic [1:0]  cand;

    logic [6:0]  addr_arr  [4];
    logic [7:0]  wdata_arr [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[7*gi +: 7];
            assign wdata_arr[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;
    logic        tmo_hit;

    // Fires in the TIMEOUT_CYCLES-th WAIT cycle; zero behaves like one.
    assign tmo_hit = ({1'b0, tmo_cnt_q} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};
`else
    logic        unused_tmo;

    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    // HOLD spans HOLDOFF_CYCLES cycles, but never fewer than one.
    assign hold_last = ({1'b0, hold_cnt_q} + 9'd1) >= {1'b0, HOLDOFF_CYCLES};

    // Search starts just after the previous winner; offset 4 wraps back to it.
    always_comb begin
        winner     = last_q;
        winner_vld = 1'b0;
        cand       = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!winner_vld && req[cand]) begin
                winner     = cand;
                winner_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        rdata_d    = rdata_q;
        nack_d     = nack_q;
        m_addr_d   = m_addr_q;
        m_rw_d     = m_rw_q;
        m_wdata_d  = m_wdata_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
`ifdef I2C_ARB_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
        abort_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (winner_vld) begin
                    state_d   = ISSUE;
                    gnt_d     = 4'b0001 << winner;
                    last_d    = winner;
                    m_addr_d  = addr_arr[winner];
                    m_rw_d    = req_rw[winner];
                    m_wdata_d = wdata_arr[winner];
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT: begin
                // A completion in the same cycle as the timeout wins.
                if (m_done) begin
                    if (m_rw_q) begin
                        rdata_d = m_rdata;
                    end
                    nack_d     = ~m_ack_ok;
                    done_d     = gnt_q;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
`ifdef I2C_ARB_TIMEOUT_EN
                    err_d      = 1'b0;
                end else if (tmo_hit) begin
                    abort_d    = 1'b1;
                    err_d      = 1'b1;
                    nack_d     = 1'b1;
                    done_d     = gnt_q;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + 16'd1;
`endif
                end
            end
            HOLD: begin
                if (hold_last) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            nack_q     <= 1'b0;
            m_addr_q   <= '0;
            m_rw_q     <= 1'b0;
            m_wdata_q  <= '0;
            last_q     <= 2'd3;
            hold_cnt_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            nack_q     <= nack_d;
            m_addr_q   <= m_addr_d;
            m_rw_q     <= m_rw_d;
            m_wdata_q  <= m_wdata_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign nack    = nack_q;
    assign busy    = (state_q != IDLE);
    assign m_start = (state_q == ISSUE);
    assign m_addr  = m_addr_q;
    assign m_rw    = m_rw_q;
    assign m_wdata = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign m_abort     = abort_q;
    assign err_timeout = err_q;
`else
    assign m_abort     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd65535: clk_50 cycles allowed in WAIT before abort.
REQ-002 Parameter HOLDOFF_CYCLES, default 8'd8: bus-free clk_50 cycles between transactions.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows; requester i occupies bit i, or slice [8i+7:8i] for data and [7i+6:7i] for addresses:
- clk_50  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-high reset
- req  in  4  per-requester transaction request, level
- req_addr  in  28  packed 7-bit slave addresses
- req_rw  in  4  per-requester direction, 1 = read
- req_wdata  in  32  packed write bytes
- gnt  out  4  one-hot grant
- done  out  4  one-cycle completion pulse per requester
- rdata  out  8  read byte of the last transaction
- nack  out  1  last transaction NACKed
- err_timeout  out  1  last transaction aborted by timeout
- busy  out  1  high in any state except IDLE
- m_start  out  1  one-cycle start pulse to the I2C master
- m_addr  out  7  slave address to the master
- m_rw  out  1  direction to the master
- m_wdata  out  8  write byte to the master
- m_abort  out  1  one-cycle abort pulse to the master
- m_done  in  1  master transaction-complete pulse
- m_ack_ok  in  1  master status, 1 = slave ACKed, valid with m_done
- m_rdata  in  8  master read byte, valid with m_done

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, WAIT and HOLD.
REQ-006 In IDLE with req != 0, the block SHALL select a winner round-robin, searching from last+1 modulo 4, register gnt, latch addr/rw/wdata into m_addr/m_rw/m_wdata, and enter ISSUE on the next edge.
REQ-007 The round-robin pointer "last" SHALL update to the winner at grant; with all four requesting, grants SHALL rotate 0,1,2,3,0.
REQ-008 ISSUE SHALL last exactly one cycle, with m_start=1 during it; the block SHALL then enter WAIT.
REQ-009 m_done SHALL be sampled only in WAIT; an m_done in ISSUE, IDLE or HOLD SHALL be ignored.
REQ-010 In WAIT, on m_done=1 the block SHALL do all of the following on the same edge: capture rdata<=m_rdata (reads only; writes keep the previous rdata); set nack<=~m_ack_ok; clear err_timeout; pulse done[winner] for one cycle; clear gnt; enter HOLD.
REQ-011 HOLD SHALL last exactly HOLDOFF_CYCLES cycles and then return to IDLE; new requests SHALL wait.
REQ-012 With HOLDOFF_CYCLES=0, HOLD SHALL last one cycle.
REQ-013 If a requester drops req after being granted, the transaction SHALL still complete and done SHALL still pulse.
REQ-014 The m_addr, m_rw and m_wdata outputs SHALL stay stable from grant until the exit from WAIT.
REQ-015 Requester inputs SHALL be ignored outside IDLE.
REQ-016 gnt SHALL be one-hot or zero at all times; done SHALL be one-hot or zero at all times.
REQ-017 The nack, err_timeout and rdata outputs SHALL hold until the next completion.

Reset
REQ-018 While rst=1, the block SHALL force state=IDLE, gnt=0, done=0, rdata=0, nack=0, err_timeout=0, busy=0, m_start=0, m_addr=0, m_rw=0, m_wdata=0, m_abort=0, last=3, and the timeout and holdoff counters to 0.
REQ-019 Reset asserted mid-transaction SHALL drop the transaction silently, with no done pulse and no m_abort pulse.
REQ-020 The first grant after reset SHALL favour requester 0.

Configuration
REQ-021 The macro I2C_ARB_TIMEOUT_EN, when defined, SHALL enable the 16-bit WAIT counter, cleared on entry to WAIT.
REQ-022 With I2C_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without m_done, the block SHALL pulse m_abort and done[winner] for one cycle, set err_timeout=1 and nack=1, leave rdata unchanged, clear gnt and enter HOLD.
REQ-023 With I2C_ARB_TIMEOUT_EN defined, m_done arriving in the same cycle as the timeout SHALL take precedence, with no abort.
REQ-024 Without I2C_ARB_TIMEOUT_EN, the block SHALL contain no counter, m_abort and err_timeout SHALL be tied to 0, and WAIT SHALL persist until m_done.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Single read: req=4'b0010, addr1=7'h1B, rw1=1; m_done with m_ack_ok=1, m_rdata=8'h5A after 20 cycles -> m_start one cycle after grant with m_addr=7'h1B, then done=4'b0010 and rdata=8'h5A, nack=0.
- Fairness: req=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with exactly HOLDOFF_CYCLES idle cycles between done and the next m_start.
- NACK write: requester 2 writes wdata=8'hDE; m_done with m_ack_ok=0 -> done=4'b0100, nack=1, rdata unchanged.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100): m_done never asserted -> m_abort and done[i] at cycle 100 of WAIT, err_timeout=1; same stimulus without the macro -> busy stays 1 indefinitely.
- Reset mid-WAIT: rst pulsed for one cycle -> all outputs 0 next cycle, no done pulse; the following grant goes to requester 0.
- Stray m_done during HOLD and req dropped during WAIT -> no extra done; the original done still pulses.
